// File: rtl/line_transfer_unit_pkg.sv
// rtl/line_transfer_unit_pkg.sv - memory-port command encodings shared with main memory
package line_transfer_unit_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MEM_IDLE = 2'b00;
  localparam mem_cmd_t READ     = 2'b01;
  localparam mem_cmd_t WRITE    = 2'b10;

endpackage

// File: rtl/line_transfer_unit.sv
// rtl/line_transfer_unit.sv - cache-line fill/writeback master for the 32-bit memory port
module line_transfer_unit
  import line_transfer_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [LEN*LINE_WORDS-1:0]  req_wdata,
  output logic                       resp_valid,
  output logic [LEN*LINE_WORDS-1:0]  resp_rdata,
  output logic [1:0]                 mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]      mem_vis_addr,
  output logic [LEN-1:0]             writen_data,
  input  logic [LEN-1:0]             mem_data
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int WSH = $clog2(LEN / BYTE_SIZE);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS * (LEN / BYTE_SIZE) - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_RD_DRAIN = 3'd2;
  localparam logic [2:0] S_WR       = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]                r_state;
  logic [BW-1:0]             r_beat;
  logic [BW-1:0]             r_cap_idx;
  logic [ADDR_WIDTH-1:0]     r_base;
  logic [LEN*LINE_WORDS-1:0] r_wline;
  logic [LEN*LINE_WORDS-1:0] r_rline;
  logic                      r_resp_valid;
  mem_cmd_t                  r_mem_cmd;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [LEN-1:0]            r_wdata;

  logic [BW-1:0]         w_beat_nxt;
  logic [ADDR_WIDTH-1:0] w_req_base;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;

  assign w_beat_nxt = r_beat + 1'b1;
  assign w_req_base = req_addr & ~OFF_MASK;
  // base is line aligned, so OR-ing the word offset never carries into line bits
  assign w_nxt_addr = r_base | (ADDR_WIDTH'(w_beat_nxt) << WSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_cap_idx    <= '0;
      r_base       <= '0;
      r_wline      <= '0;
      r_rline      <= '0;
      r_resp_valid <= 1'b0;
      r_mem_cmd    <= MEM_IDLE;
      r_mem_addr   <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_base     <= w_req_base;
            r_wline    <= req_wdata;
            r_beat     <= '0;
            r_cap_idx  <= '0;
            r_mem_addr <= w_req_base;
            if (req_write) begin
              r_state   <= S_WR;
              r_mem_cmd <= WRITE;
              r_wdata   <= req_wdata[LEN-1:0];
            end else begin
              r_state   <= S_RD;
              r_mem_cmd <= READ;
            end
          end
        end
        S_RD: begin
          // memory returns data one cycle after sampling READ, so capture lags the beat by one
          if (r_beat != '0) begin
            r_rline[LEN*r_cap_idx +: LEN] <= mem_data;
            r_cap_idx                     <= r_cap_idx + 1'b1;
          end
          if (r_beat == LAST_BEAT) begin
            r_state   <= S_RD_DRAIN;
            r_mem_cmd <= MEM_IDLE;
          end else begin
            r_beat     <= w_beat_nxt;
            r_mem_addr <= w_nxt_addr;
          end
        end
        S_RD_DRAIN: begin
          r_rline[LEN*r_cap_idx +: LEN] <= mem_data;
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
        end
        S_WR: begin
          if (r_beat == LAST_BEAT) begin
            r_state      <= S_DONE;
            r_mem_cmd    <= MEM_IDLE;
            r_resp_valid <= 1'b1;
          end else begin
            r_beat     <= w_beat_nxt;
            r_mem_addr <= w_nxt_addr;
            r_wdata    <= r_wline[LEN*w_beat_nxt +: LEN];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_cmd <= MEM_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_rline;
  assign mem_vis_signal = r_mem_cmd;
  assign mem_vis_addr   = r_mem_addr;
  assign writen_data    = r_wdata;

endmodule

// File: tb/tb_line_transfer_unit.sv
// tb/tb_line_transfer_unit.sv - scoreboard bench for line_transfer_unit with a byte memory model
module tb_line_transfer_unit;
  import line_transfer_unit_pkg::*;

  localparam int AW  = 17;
  localparam int LEN = 32;
  localparam int LW  = 4;
  localparam int LB  = LEN * LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_write, resp_valid;
  logic [AW-1:0] req_addr, mem_vis_addr;
  logic [LB-1:0] req_wdata, resp_rdata;
  logic [1:0]    mem_vis_signal;
  logic [LEN-1:0] writen_data;
  logic [LEN-1:0] mem_data = '0;

  always #5 clk = ~clk;

  line_transfer_unit #(.ADDR_WIDTH(AW), .LEN(LEN), .BYTE_SIZE(8), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .writen_data(writen_data), .mem_data(mem_data)
  );

  typedef struct { int cyc; logic [1:0] cmd; logic [AW-1:0] addr; logic [LEN-1:0] data; } beat_t;
  typedef struct { int cyc; logic [LB-1:0] rdata; } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t mb;
  resp_t mr;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_resp = 0;
  logic [LB-1:0] last_fill = '0;

  // byte-addressed main memory with a registered read port and a preload port
  logic [7:0]     mem [0:(1<<AW)-1];
  logic           pl_en = 1'b0;
  logic [AW-1:0]  pl_addr = '0;
  logic [LEN-1:0] pl_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) begin
      for (int b = 0; b < 4; b++) mem[int'(pl_addr) + b] <= pl_data[8*b +: 8];
    end else if (mem_vis_signal == WRITE) begin
      for (int b = 0; b < 4; b++) mem[int'(mem_vis_addr) + b] <= writen_data[8*b +: 8];
    end
    if (mem_vis_signal == READ)
      mem_data <= {mem[int'(mem_vis_addr) + 3], mem[int'(mem_vis_addr) + 2],
                   mem[int'(mem_vis_addr) + 1], mem[int'(mem_vis_addr)]};
  end

  function automatic logic [LEN-1:0] rd_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_vis_signal != MEM_IDLE) begin
        check("beat_expected", LB'(beat_q.size() != 0), LB'(1'b1));
        if (beat_q.size() != 0) begin
          mb = beat_q.pop_front();
          check("beat_cyc", LB'(cyc), LB'(mb.cyc));
          check("beat_cmd", LB'(mem_vis_signal), LB'(mb.cmd));
          check("beat_addr", LB'(mem_vis_addr), LB'(mb.addr));
          if (mb.cmd == WRITE) check("beat_wdata", LB'(writen_data), LB'(mb.data));
        end
      end
      if (resp_valid) begin
        n_resp++;
        check("resp_expected", LB'(resp_q.size() != 0), LB'(1'b1));
        if (resp_q.size() != 0) begin
          mr = resp_q.pop_front();
          check("resp_cyc", LB'(cyc), LB'(mr.cyc));
          check("resp_rdata", resp_rdata, mr.rdata);
        end
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [LEN-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // drives a request (leaving req_valid high), waits for acceptance and pushes expectations
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LB-1:0] wd, output int acc);
    logic [AW-1:0] base;
    logic [LB-1:0] line;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_accept", LB'(ok), LB'(1'b1));
    @(posedge clk);
    #1;
    acc = cyc;
    base = a & ~AW'(LW * 4 - 1);
    for (int k = 0; k < LW; k++) begin
      line[LEN*k +: LEN] = rd_word(int'(base) + 4 * k);
      beat_q.push_back('{acc + k, wr ? WRITE : READ, base + AW'(4 * k), wd[LEN*k +: LEN]});
    end
    if (wr) begin
      resp_q.push_back('{acc + LW, last_fill});
    end else begin
      resp_q.push_back('{acc + LW + 1, line});
      last_fill = line;
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (req_ready && beat_q.size() == 0 && resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, LB'(ok), LB'(1'b1));
  endtask

  int acc0, acc1, r0;
  logic [LEN-1:0] w400;

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", LB'(req_ready), LB'(1'b1));
    check("rst_resp_valid", LB'(resp_valid), LB'(1'b0));
    check("rst_resp_rdata", resp_rdata, '0);
    check("rst_mem_cmd", LB'(mem_vis_signal), LB'(MEM_IDLE));
    check("rst_mem_addr", LB'(mem_vis_addr), '0);
    check("rst_wdata", LB'(writen_data), '0);

    preload(17'h100, 32'h11111111);
    preload(17'h104, 32'h22222222);
    preload(17'h108, 32'h33333333);
    preload(17'h10C, 32'h44444444);
    preload(17'h1FFF0, 32'h0BADF00D);
    preload(17'h1FFF4, 32'hCAFEBABE);
    preload(17'h1FFF8, 32'h12345678);
    preload(17'h1FFFC, 32'h9ABCDEF0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 17'h105, '0, acc0);
    req_valid = 1'b0;
    wait_done("fill_done");
    check("fill_line", resp_rdata, 128'h44444444_33333333_22222222_11111111);

    issue(1'b1, 17'h200, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, acc0);
    req_valid = 1'b0;
    wait_done("wb_done");
    check("wb_byte_200", LB'(mem[17'h200]), LB'(8'hAA));
    check("wb_word_20c", LB'(rd_word(32'h20C)), LB'(32'hDDDDDDDD));
    check("wb_keeps_rdata", resp_rdata, 128'h44444444_33333333_22222222_11111111);

    r0 = n_resp;
    issue(1'b0, 17'h100, '0, acc0);
    issue(1'b1, 17'h240, 128'h04040404_03030303_02020202_01010101, acc1);
    req_valid = 1'b0;
    wait_done("b2b_done");
    check("b2b_gap", LB'(acc1 - acc0), LB'(LW + 3));
    check("b2b_resp_count", LB'(n_resp - r0), LB'(2));

    issue(1'b0, 17'h1FFF0, '0, acc0);
    req_valid = 1'b0;
    wait_done("top_done");
    check("top_line", resp_rdata, 128'h9ABCDEF0_12345678_CAFEBABE_0BADF00D);

    r0 = n_resp;
    issue(1'b0, 17'h100, '0, acc0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    beat_q.delete();
    resp_q.delete();
    last_fill = '0;
    #1;
    check("rst_mid_cmd", LB'(mem_vis_signal), LB'(MEM_IDLE));
    check("rst_mid_resp_valid", LB'(resp_valid), LB'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LW + 4) @(negedge clk);
    #1;
    check("rst_mid_ready", LB'(req_ready), LB'(1'b1));
    check("rst_mid_no_resp", LB'(n_resp), LB'(r0));
    check("rst_mid_rdata", resp_rdata, '0);

    r0 = n_resp;
    w400 = rd_word(32'h400);
    issue(1'b1, 17'h300, 128'h89898989_67676767_45454545_23232323, acc0);
    @(negedge clk);
    req_addr = 17'h400; req_wdata = {LW{32'h5A5A5A5A}};
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("busy_done");
    check("busy_word_300", LB'(rd_word(32'h300)), LB'(32'h23232323));
    check("busy_word_30c", LB'(rd_word(32'h30C)), LB'(32'h89898989));
    check("busy_word_400", LB'(rd_word(32'h400)), LB'(w400));
    check("busy_resp_count", LB'(n_resp - r0), LB'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
